// File: rtl/start_fifo_srl_ctrl_pkg.sv
// Shared defaults and occupancy-state encoding for the SRL start-token FIFO.
package start_fifo_srl_ctrl_pkg;
  localparam int unsigned DEPTH_DEF      = 9;
  localparam int unsigned ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_state_t;
endpackage

// File: rtl/start_fifo_srl_ctrl_storage.sv
// Shift-register token array: a write shifts every entry up by one and lands din in entry 0.
module start_fifo_srl_storage
  import start_fifo_srl_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] r_sreg [DEPTH];

  // No reset: contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (we) begin
      r_sreg[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        r_sreg[i] <= r_sreg[i-1];
      end
    end
  end

  assign dout = r_sreg[addr];

endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// Start-token FIFO control: occupancy FSM, read-address tracking and registered full/empty flags
// around a shift-register array, with first-word-fall-through output.
//
//   state       | meaning
//   ------------+----------------------------------------------
//   OCC_EMPTY   | count == 0, if_empty_n = 0, pops refused
//   OCC_PARTIAL | 1 <= count <= DEPTH-1, both flags high
//   OCC_FULL    | count == DEPTH, if_full_n = 0, pushes refused
module start_fifo_srl_ctrl
  import start_fifo_srl_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  if_full_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_empty_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]   if_num_data_valid,
  output logic [ADDR_WIDTH:0]   if_fifo_cap
);

  localparam logic [ADDR_WIDTH:0]   C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   C_ONE   = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   C_LAST  = (ADDR_WIDTH+1)'(DEPTH-1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE   = ADDR_WIDTH'(1);

  occ_state_t            r_state, w_state_nxt;
  logic [ADDR_WIDTH:0]   r_count, w_count_nxt;
  logic [ADDR_WIDTH-1:0] r_raddr, w_raddr_nxt;
  logic                  r_empty_n, r_full_n;
  logic                  w_empty_n_nxt, w_full_n_nxt;
  logic                  w_push, w_pop;

  assign w_push = if_write & if_write_ce & r_full_n;
  assign w_pop  = if_read  & if_read_ce  & r_empty_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= OCC_EMPTY;
      r_count   <= '0;
      r_raddr   <= '0;
      r_empty_n <= 1'b0;
      r_full_n  <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_raddr   <= w_raddr_nxt;
      r_empty_n <= w_empty_n_nxt;
      r_full_n  <= w_full_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_raddr_nxt = r_raddr;

    // Push+pop together leaves raddr alone: the shift moves the next-oldest entry under it.
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + C_ONE;
      if (r_count != '0) w_raddr_nxt = r_raddr + A_ONE;
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - C_ONE;
      if (r_count != C_ONE) w_raddr_nxt = r_raddr - A_ONE;
    end

    case (r_state)
      OCC_EMPTY: begin
        if (w_push) w_state_nxt = OCC_PARTIAL;
      end
      OCC_PARTIAL: begin
        if (w_push && !w_pop && r_count == C_LAST)     w_state_nxt = OCC_FULL;
        else if (w_pop && !w_push && r_count == C_ONE) w_state_nxt = OCC_EMPTY;
      end
      OCC_FULL: begin
        if (w_pop) w_state_nxt = OCC_PARTIAL;
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase

    w_empty_n_nxt = (w_state_nxt != OCC_EMPTY);
    w_full_n_nxt  = (w_state_nxt != OCC_FULL);
  end

  start_fifo_srl_storage #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_storage (
    .clk  (clk),
    .we   (w_push),
    .addr (r_raddr),
    .din  (if_din),
    .dout (if_dout)
  );

  assign if_full_n         = r_full_n;
  assign if_empty_n        = r_empty_n;
  assign if_num_data_valid = r_count;
  assign if_fifo_cap       = C_DEPTH;

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// Bench for start_fifo_srl_ctrl: directed scenarios plus random traffic against a queue model.
module tb_start_fifo_srl_ctrl;
  localparam int DEPTH = 9;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       if_full_n, if_empty_n;
  logic       if_write_ce = 1'b0, if_write = 1'b0, if_din = 1'b0;
  logic       if_read_ce = 1'b0, if_read = 1'b0;
  logic       if_dout;
  logic [4:0] if_num_data_valid, if_fifo_cap;

  int total = 0;
  int bad   = 0;
  bit q[$];

  always #5 clk = ~clk;

  start_fifo_srl_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .if_full_n         (if_full_n),
    .if_write_ce       (if_write_ce),
    .if_write          (if_write),
    .if_din            (if_din),
    .if_empty_n        (if_empty_n),
    .if_read_ce        (if_read_ce),
    .if_read           (if_read),
    .if_dout           (if_dout),
    .if_num_data_valid (if_num_data_valid),
    .if_fifo_cap       (if_fifo_cap)
  );

  // Expected {empty_n, full_n, count} straight from the queue model.
  function automatic logic [6:0] exp_status();
    return {q.size() != 0, q.size() != DEPTH, 5'(q.size())};
  endfunction

  // Drive one cycle of stimulus and advance the model; returns at posedge+1.
  task automatic step(input bit w, input bit wce, input bit d, input bit r, input bit rce);
    bit push, pop;
    if_write = w; if_write_ce = wce; if_din = d; if_read = r; if_read_ce = rce;
    push = w && wce && (q.size() < DEPTH);
    pop  = r && rce && (q.size() > 0);
    @(posedge clk);
    if (pop)  void'(q.pop_front());
    if (push) q.push_back(d);
    #1;
    if_write = 0; if_write_ce = 0; if_read = 0; if_read_ce = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0);
      total++;
      if ({if_empty_n, if_full_n, if_num_data_valid} !== 7'b01_00000) begin
        bad++;
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {if_empty_n, if_full_n, if_num_data_valid}, 7'b01_00000);
      end
    end
    total++;
    if (if_fifo_cap !== 5'd9) begin
      bad++;
      $display("FAIL fifo_cap got=%0d want=9", if_fifo_cap);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 1, 0);
      total++;
      if ({if_empty_n, if_full_n, if_num_data_valid} !== 7'b01_00000) begin
        bad++;
        $display("FAIL ce_gate cyc=%0d got=%b want=%b", i, {if_empty_n, if_full_n, if_num_data_valid}, 7'b01_00000);
      end
    end
  endtask

  task automatic test_basic_seq();
    bit wdat [3] = '{1'b1, 1'b0, 1'b1};
    int ecnt [6] = '{1, 2, 3, 2, 1, 0};
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        step(1, 1, wdat[i], 0, 0);
      end else begin
        total++;
        if (if_dout !== wdat[i-3]) begin
          bad++;
          $display("FAIL basic_dout idx=%0d got=%b want=%b", i-3, if_dout, wdat[i-3]);
        end
        step(0, 0, 0, 1, 1);
      end
      total++;
      if (if_num_data_valid !== 5'(ecnt[i]) || if_empty_n !== (ecnt[i] != 0)) begin
        bad++;
        $display("FAIL basic_count step=%0d got=%0d/%b want=%0d/%b", i, if_num_data_valid, if_empty_n, ecnt[i], ecnt[i] != 0);
      end
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) step(1, 1, 1'($urandom), 0, 0);
    total++;
    if (if_full_n !== 1'b0 || if_num_data_valid !== 5'd9) begin
      bad++;
      $display("FAIL fill_full got full_n=%b cnt=%0d want 0/9", if_full_n, if_num_data_valid);
    end
    step(1, 1, ~q[DEPTH-1], 0, 0);
    total++;
    if (if_num_data_valid !== 5'd9 || if_full_n !== 1'b0) begin
      bad++;
      $display("FAIL fill_overflow got cnt=%0d full_n=%b want 9/0", if_num_data_valid, if_full_n);
    end
    for (int i = 0; i < DEPTH; i++) begin
      total++;
      if (if_dout !== q[0]) begin
        bad++;
        $display("FAIL fill_order idx=%0d got=%b want=%b", i, if_dout, q[0]);
      end
      step(0, 0, 0, 1, 1);
    end
    total++;
    if ({if_empty_n, if_full_n, if_num_data_valid} !== 7'b01_00000) begin
      bad++;
      $display("FAIL fill_drained got=%b want=%b", {if_empty_n, if_full_n, if_num_data_valid}, 7'b01_00000);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) step(1, 1, 1'($urandom), 0, 0);
    for (int i = 0; i < 20; i++) begin
      total++;
      if (if_dout !== q[0]) begin
        bad++;
        $display("FAIL b2b_dout cyc=%0d got=%b want=%b", i, if_dout, q[0]);
      end
      step(1, 1, 1'(i & 1), 1, 1);
      total++;
      if ({if_empty_n, if_full_n, if_num_data_valid} !== 7'b11_00100) begin
        bad++;
        $display("FAIL b2b_status cyc=%0d got=%b want=%b", i, {if_empty_n, if_full_n, if_num_data_valid}, 7'b11_00100);
      end
    end
    while (q.size() != 0) begin
      total++;
      if (if_dout !== q[0]) begin
        bad++;
        $display("FAIL b2b_drain got=%b want=%b", if_dout, q[0]);
      end
      step(0, 0, 0, 1, 1);
    end
  endtask

  task automatic test_full_edges();
    for (int i = 0; i < DEPTH; i++) step(1, 1, 1'($urandom), 0, 0);
    step(1, 1, 1'($urandom), 1, 1);
    total++;
    if ({if_empty_n, if_full_n, if_num_data_valid} !== 7'b11_01000) begin
      bad++;
      $display("FAIL full_pushpop got=%b want=%b", {if_empty_n, if_full_n, if_num_data_valid}, 7'b11_01000);
    end
    while (q.size() != 0) begin
      total++;
      if (if_dout !== q[0]) begin
        bad++;
        $display("FAIL full_drain got=%b want=%b", if_dout, q[0]);
      end
      step(0, 0, 0, 1, 1);
    end
    step(1, 1, 1'b1, 1, 1);
    total++;
    if ({if_empty_n, if_full_n, if_num_data_valid, if_dout} !== 8'b11_00001_1) begin
      bad++;
      $display("FAIL empty_pushpop got=%b want=%b", {if_empty_n, if_full_n, if_num_data_valid, if_dout}, 8'b11_00001_1);
    end
    step(0, 0, 0, 1, 1);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, 1, 1'($urandom), 0, 0);
    #2 reset = 1'b1;
    #1;
    q.delete();
    total++;
    if ({if_empty_n, if_full_n, if_num_data_valid} !== 7'b01_00000) begin
      bad++;
      $display("FAIL async_reset got=%b want=%b", {if_empty_n, if_full_n, if_num_data_valid}, 7'b01_00000);
    end
    @(negedge clk);
    reset = 1'b0;
    step(1, 1, 1'b0, 0, 0);
    step(1, 1, 1'b1, 0, 0);
    total++;
    if (if_dout !== 1'b0 || if_num_data_valid !== 5'd2) begin
      bad++;
      $display("FAIL after_reset got dout=%b cnt=%0d want 0/2", if_dout, if_num_data_valid);
    end
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 9) != 0), 1'($urandom),
           1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 9) != 0));
      total++;
      if ({if_empty_n, if_full_n, if_num_data_valid} !== exp_status()) begin
        bad++;
        $display("FAIL rand_status cyc=%0d got=%b want=%b", i, {if_empty_n, if_full_n, if_num_data_valid}, exp_status());
      end
      if (q.size() != 0) begin
        total++;
        if (if_dout !== q[0]) begin
          bad++;
          $display("FAIL rand_dout cyc=%0d got=%b want=%b", i, if_dout, q[0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_seq();
    test_fill();
    test_back_to_back();
    test_full_edges();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/start_fifo_srl_ctrl.md
Name: start_fifo_srl_ctrl

Overview:
- SRL-based start-token FIFO that sits between a dataflow producer and a PE instance, such as PE_i4xi4 in Linear_Layer_i4xi4_q.
- Adds a full/empty ap_fifo handshake, occupancy tracking and read-address generation around a shift-register storage array.
- Output is first-word-fall-through: the oldest entry is always visible on if_dout while if_empty_n=1.
- The producer's ap_start/ap_done chain writes it; the PE's start logic reads it.

Parameters:
- DATA_WIDTH, 1, width of each stored token.
- ADDR_WIDTH, 4, width of the read address and occupancy counter; must satisfy 2**ADDR_WIDTH >= DEPTH.
- DEPTH, 9, number of entries (minimum 2).

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-high reset.
- if_full_n  out  1  registered; 1 = space available.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_empty_n  out  1  registered; 1 = data available.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request.
- if_dout  out  DATA_WIDTH  oldest entry (FWFT).
- if_num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- if_fifo_cap  out  ADDR_WIDTH+1  constant DEPTH.

Behaviour:
- Reset (asynchronous assert, synchronous release): count=0, raddr=0, if_empty_n=0, if_full_n=1, if_num_data_valid=0.
  - Storage contents are not reset.
  - if_dout is don't-care while if_empty_n=0.
- Qualified operations:
  - push = if_write & if_write_ce & if_full_n.
  - pop = if_read & if_read_ce & if_empty_n.
  - Unqualified requests are ignored: no state change and no error.
- Storage: on push, the array shifts by one (entry i goes to i+1) and if_din goes to entry 0. if_dout = array[raddr], combinational from the array and the raddr register.
- Occupancy state derived from count: EMPTY (0), PARTIAL (1..DEPTH-1), FULL (DEPTH).
- push only:
  - count+1.
  - raddr+1, except raddr stays 0 when count was 0.
  - EMPTY->PARTIAL, or PARTIAL->FULL when count reaches DEPTH.
- pop only:
  - count-1.
  - raddr-1, except raddr stays 0 when count becomes 0.
  - FULL->PARTIAL, or PARTIAL->EMPTY when count was 1.
- push and pop together (PARTIAL only): count and raddr are unchanged; the shift keeps raddr pointing at the new oldest entry.
- Simultaneous requests at EMPTY: only the push qualifies, so it behaves as push only.
- Simultaneous requests at FULL: only the pop qualifies, so it behaves as pop only. The write is refused that cycle; if_full_n rises the next cycle.
- Flags are registered from next-state count:
  - if_empty_n_next = (count_next != 0).
  - if_full_n_next = (count_next != DEPTH).
- Latency:
  - Data written at edge N: if_empty_n=1 and valid if_dout after edge N (1-cycle write-to-read).
  - A pop at edge N shows the next entry on if_dout immediately after edge N.
- if_num_data_valid equals count (registered). if_fifo_cap is tied to DEPTH.
- Clock-enables low hold all state, including the flags.
- Reset asserted mid-operation: immediate return to EMPTY, regardless of clk.
- Illegal states (count > DEPTH) are unreachable; no assertion logic in RTL.

Decomposition:
- Shared package: DEPTH/ADDR_WIDTH defaults and the occupancy-state enum (EMPTY, PARTIAL, FULL).
- One sub-module: start_fifo_srl_storage, a DATA_WIDTH x DEPTH shift array with ports clk, we, addr, din, dout and no reset.
- The control (counter, raddr, flags) stays in the top module.

Test Plan:
- Reset then idle -> if_empty_n=0, if_full_n=1, if_num_data_valid=0 for 10 cycles; write with if_write_ce=0 -> no change.
- Write 1,0,1 on consecutive cycles, then read 3 -> if_dout sequence 1,0,1; if_empty_n drops the cycle after the third read; num_data_valid goes 1,2,3,2,1,0.
- Fill with 9 writes (DEPTH=9) -> if_full_n=0 after the 9th edge; a 10th write is ignored and count stays 9; read-out order matches write order.
- At count=4, assert push+pop for 20 cycles with alternating data -> count stays 4, if_dout follows FIFO order, both flags stay 1.
- At FULL, push+pop in the same cycle -> count=8, the write is dropped, if_full_n=1 next cycle. At EMPTY, push+pop -> count=1, if_empty_n=1 next cycle.
- Assert reset asynchronously at count=5, between clock edges -> flags and count clear before the next edge; a write after release is read back first.
